// File: rtl/mips_perf_pkg.sv
// Shared constants and FSM encoding for the perf-counter serial readout.
// Frame layout: sync byte, NUM_CNT counter words MSB first, XOR checksum byte.
package mips_perf_pkg;

    localparam int         PERF_NUM_CNT    = 8;
    localparam int         PERF_FRAME_BITS = 272;
    localparam logic [7:0] PERF_SYNC       = 8'hA5;

    localparam int CNT_CYCLE = 0;
    localparam int CNT_INST  = 1;
    localparam int CNT_BR    = 2;
    localparam int CNT_LD    = 3;
    localparam int CNT_ST    = 4;
    localparam int CNT_USER1 = 5;
    localparam int CNT_USER2 = 6;
    localparam int CNT_USER3 = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } perf_state_e;

endpackage

// File: rtl/perf_bit_shifter.sv
// Bit-rate divider plus load/shift register: emits a loaded byte or word MSB first,
// each bit held BIT_DIV clocks, and flags word_done on the last clock of the last bit.
module perf_bit_shifter #(
    parameter int WORD_W  = 32,
    parameter int BIT_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_word,
    input  logic [WORD_W-1:0] load_data,
    output logic              ser_bit,
    output logic              active,
    output logic              word_done
);

    localparam int DIV_W  = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BCNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic              active_q, active_d;
    logic              div_wrap;

    assign div_wrap  = (div_q == DIV_W'(BIT_DIV - 1));
    assign word_done = active_q && div_wrap && (bit_cnt_q == '0);

    // A load on the word_done cycle chains words with no gap bit.
    always_comb begin
        sreg_d    = sreg_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;
        if (load) begin
            sreg_d    = load_word ? load_data : {load_data[7:0], {(WORD_W-8){1'b0}}};
            bit_cnt_d = load_word ? BCNT_W'(WORD_W - 1) : BCNT_W'(7);
            div_d     = '0;
            active_d  = 1'b1;
        end else if (active_q) begin
            if (div_wrap) begin
                div_d = '0;
                if (bit_cnt_q == '0) begin
                    active_d = 1'b0;
                    sreg_d   = '0;
                end else begin
                    sreg_d    = {sreg_q[WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - BCNT_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q    <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            active_q  <= active_d;
        end
    end

    assign ser_bit = sreg_q[WORD_W-1];
    assign active  = active_q;

endmodule

// File: rtl/mips_perf_serializer.sv
// Snapshots the eight CPU perf counters on request or periodic tick and streams
// them on one pin as sync byte, counter words and XOR checksum.
module mips_perf_serializer
    import mips_perf_pkg::*;
#(
    parameter int NUM_CNT     = PERF_NUM_CNT,
    parameter int CNT_W       = 32,
    parameter int BIT_DIV     = 1,
    parameter int AUTO_PERIOD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cycle_cnt,
    input  logic [CNT_W-1:0] inst_cnt,
    input  logic [CNT_W-1:0] br_cnt,
    input  logic [CNT_W-1:0] ld_cnt,
    input  logic [CNT_W-1:0] st_cnt,
    input  logic [CNT_W-1:0] user1_cnt,
    input  logic [CNT_W-1:0] user2_cnt,
    input  logic [CNT_W-1:0] user3_cnt,
    input  logic             snap_req,
    output logic             busy,
    output logic             done,
    output logic             ser_en,
    output logic             ser_data
);

    localparam int                IDX_W    = $clog2(NUM_CNT);
    localparam int                AUTO_W   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CNT - 1);

    perf_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_in [NUM_CNT];
    logic [CNT_W-1:0]  snap_q [NUM_CNT];
    logic [CNT_W-1:0]  snap_d [NUM_CNT];
    logic [IDX_W-1:0]  word_idx_q, word_idx_d, next_idx;
    logic [7:0]        csum_q, csum_d, csum_in;
    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              auto_tick, accept;
    logic              sh_load, sh_load_word;
    logic [CNT_W-1:0]  sh_load_data;
    logic              sh_bit, sh_active, sh_word_done;

    assign cnt_in[CNT_CYCLE] = cycle_cnt;
    assign cnt_in[CNT_INST]  = inst_cnt;
    assign cnt_in[CNT_BR]    = br_cnt;
    assign cnt_in[CNT_LD]    = ld_cnt;
    assign cnt_in[CNT_ST]    = st_cnt;
    assign cnt_in[CNT_USER1] = user1_cnt;
    assign cnt_in[CNT_USER2] = user2_cnt;
    assign cnt_in[CNT_USER3] = user3_cnt;

    assign next_idx  = word_idx_q + IDX_W'(1);
    assign auto_tick = (AUTO_PERIOD != 0) && (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1));
    assign accept    = (state_q == ST_IDLE) && (snap_req || auto_tick);

    // Checksum is taken from the live inputs so it is ready in the accept cycle.
    always_comb begin
        csum_in = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            for (int b = 0; b < CNT_W / 8; b++) begin
                csum_in = csum_in ^ cnt_in[i][8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SYNC;
            ST_SYNC: if (sh_word_done) state_d = ST_DATA;
            ST_DATA: if (sh_word_done && (word_idx_q == LAST_IDX)) state_d = ST_CSUM;
            ST_CSUM: if (sh_word_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with ser_en.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        sh_load      = 1'b0;
        sh_load_word = 1'b0;
        sh_load_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_load      = 1'b1;
                    sh_load_data = CNT_W'(PERF_SYNC);
                end
            end
            ST_SYNC: begin
                if (sh_word_done) begin
                    sh_load      = 1'b1;
                    sh_load_word = 1'b1;
                    sh_load_data = snap_q[0];
                end
            end
            ST_DATA: begin
                if (sh_word_done) begin
                    sh_load = 1'b1;
                    if (word_idx_q == LAST_IDX) begin
                        sh_load_data = CNT_W'(csum_q);
                    end else begin
                        sh_load_word = 1'b1;
                        sh_load_data = snap_q[next_idx];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        snap_d     = snap_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        auto_cnt_d = auto_cnt_q;
        if (accept) begin
            snap_d     = cnt_in;
            word_idx_d = '0;
            csum_d     = csum_in;
            auto_cnt_d = '0;
        end else if ((state_q == ST_IDLE) && (AUTO_PERIOD != 0)) begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        end
        if ((state_q == ST_DATA) && sh_word_done && (word_idx_q != LAST_IDX)) begin
            word_idx_d = next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= '0;
            end
            word_idx_q <= '0;
            csum_q     <= '0;
            auto_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            snap_q     <= snap_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            auto_cnt_q <= auto_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    perf_bit_shifter #(
        .WORD_W  (CNT_W),
        .BIT_DIV (BIT_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_word (sh_load_word),
        .load_data (sh_load_data),
        .ser_bit   (sh_bit),
        .active    (sh_active),
        .word_done (sh_word_done)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign ser_en   = sh_active;
    assign ser_data = sh_bit;

endmodule
